frame_timing_gen: RTL and testbench

Upstream video timing source for the frame generator. Produces Camera-Link-style FVAL/LVAL/DVAL strobes for a DVAL_HIGH × ROW_COUNT monochrome frame with programmable blanking. It also produces the one-cycle `fval_posedge` / `lval_negedge` event pulses and pixel/line indices that the pattern generator consumes directly. All outputs are registered; one frame is emitted per `en` grant, back-to-back while `en` stays high.

---
 rtl/frame_timing_pkg.sv | 23 ++
 rtl/frame_timing_gen_if.sv | 37 +++
 rtl/frame_timing_gen_phase_counter.sv | 27 ++
 rtl/frame_timing_gen.sv | 135 +++++++++++++
 tb/tb_frame_timing_gen.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_timing_pkg.sv
// Shared types and limits for the frame timing generator: state encoding,
// counter width and the legal range for every timing parameter.
package frame_timing_pkg;

    localparam int CNT_W   = 16;
    localparam int LEN_MIN = 1;
    localparam int LEN_MAX = 65535;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_V_FRONT,
        ST_ACTIVE,
        ST_H_BLANK,
        ST_V_BACK,
        ST_V_BLANK
    } state_e;

    // Every duration must be loadable as (len-1) into the CNT_W phase counter.
    function automatic bit len_ok(input int len);
        return (len >= LEN_MIN) && (len <= LEN_MAX);
    endfunction

endpackage

// File: rtl/frame_timing_gen_if.sv
// Strobe/index bundle between the timing generator and the pattern generator.
// FRAME_TIMING_FRAME_COUNT_EN adds the frame_count signal.
interface frame_timing_gen_if;
    import frame_timing_pkg::*;

    logic             en;
    logic             fval;
    logic             lval;
    logic             dval;
    logic             fval_posedge;
    logic             lval_negedge;
    logic             busy;
    logic [CNT_W-1:0] pix_idx;
    logic [CNT_W-1:0] line_idx;
`ifdef FRAME_TIMING_FRAME_COUNT_EN
    logic [CNT_W-1:0] frame_count;
`endif

    modport master (
        input  en,
        output fval, lval, dval, fval_posedge, lval_negedge, busy,
`ifdef FRAME_TIMING_FRAME_COUNT_EN
        output frame_count,
`endif
        output pix_idx, line_idx
    );

    modport slave (
        output en,
        input  fval, lval, dval, fval_posedge, lval_negedge, busy,
`ifdef FRAME_TIMING_FRAME_COUNT_EN
        input  frame_count,
`endif
        input  pix_idx, line_idx
    );

endinterface

// File: rtl/frame_timing_gen_phase_counter.sv
// State-duration down-counter: loaded with (length-1) on state entry,
// stops at zero; zero marks the last cycle of the current state.
module phase_counter
    import frame_timing_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/frame_timing_gen.sv
// Camera-Link style FVAL/LVAL/DVAL timing source with event pulses and indices.
// Optional FRAME_TIMING_FRAME_COUNT_EN adds a wrapping 16-bit frame counter.
module frame_timing_gen
    import frame_timing_pkg::*;
#(
    parameter int DVAL_HIGH = 640,
    parameter int ROW_COUNT = 480,
    parameter int H_BLANK   = 16,
    parameter int V_BLANK   = 32,
    parameter int FV_TO_LV  = 4,
    parameter int LV_TO_FV  = 4
) (
    input  logic               clk,
    input  logic               rst,
    frame_timing_gen_if.master bus
);

    if (!(len_ok(DVAL_HIGH) && len_ok(ROW_COUNT) && len_ok(H_BLANK) &&
          len_ok(V_BLANK) && len_ok(FV_TO_LV) && len_ok(LV_TO_FV))) begin : g_param_err
        $error("frame_timing_gen: timing parameter outside 1..65535");
    end

    localparam logic [CNT_W-1:0] LEN_FRONT  = CNT_W'(FV_TO_LV - 1);
    localparam logic [CNT_W-1:0] LEN_ACTIVE = CNT_W'(DVAL_HIGH - 1);
    localparam logic [CNT_W-1:0] LEN_HBLANK = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] LEN_BACK   = CNT_W'(LV_TO_FV - 1);
    localparam logic [CNT_W-1:0] LEN_VBLANK = CNT_W'(V_BLANK - 1);
    localparam logic [CNT_W-1:0] LAST_LINE  = CNT_W'(ROW_COUNT - 1);

    state_e           state, state_nxt;
    logic             ph_load, ph_zero;
    logic [CNT_W-1:0] ph_load_val;

    logic             fval_q, lval_q, fpos_q, lneg_q, busy_q;
    logic [CNT_W-1:0] pix_q, line_q;
    logic             fval_nxt, lval_nxt;
    logic [CNT_W-1:0] pix_nxt, line_nxt;

    phase_counter u_phase (
        .clk      (clk),
        .rst      (rst),
        .load     (ph_load),
        .load_val (ph_load_val),
        .dec      (state != ST_IDLE),
        .zero     (ph_zero)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (bus.en)  state_nxt = ST_V_FRONT;
            ST_V_FRONT: if (ph_zero) state_nxt = ST_ACTIVE;
            ST_ACTIVE:  if (ph_zero) state_nxt = (line_q < LAST_LINE) ? ST_H_BLANK : ST_V_BACK;
            ST_H_BLANK: if (ph_zero) state_nxt = ST_ACTIVE;
            ST_V_BACK:  if (ph_zero) state_nxt = ST_V_BLANK;
            ST_V_BLANK: if (ph_zero) state_nxt = bus.en ? ST_V_FRONT : ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    // Every transition targets a different state, so a change of state is
    // exactly a state entry and reloads the duration.
    always_comb begin
        ph_load     = (state_nxt != state);
        ph_load_val = '0;
        unique case (state_nxt)
            ST_V_FRONT: ph_load_val = LEN_FRONT;
            ST_ACTIVE:  ph_load_val = LEN_ACTIVE;
            ST_H_BLANK: ph_load_val = LEN_HBLANK;
            ST_V_BACK:  ph_load_val = LEN_BACK;
            ST_V_BLANK: ph_load_val = LEN_VBLANK;
            default:    ph_load_val = '0;
        endcase
    end

    // Outputs are computed from the next state so they are valid in the
    // first cycle of the state they belong to.
    always_comb begin
        fval_nxt = (state_nxt inside {ST_V_FRONT, ST_ACTIVE, ST_H_BLANK, ST_V_BACK});
        lval_nxt = (state_nxt == ST_ACTIVE);
        pix_nxt  = '0;
        if (lval_nxt && lval_q)
            pix_nxt = pix_q + 1'b1;
        line_nxt = line_q;
        if (!fval_nxt)
            line_nxt = '0;
        else if ((state == ST_H_BLANK) && (state_nxt == ST_ACTIVE))
            line_nxt = line_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            fval_q <= 1'b0;
            lval_q <= 1'b0;
            fpos_q <= 1'b0;
            lneg_q <= 1'b0;
            busy_q <= 1'b0;
            pix_q  <= '0;
            line_q <= '0;
        end else begin
            state  <= state_nxt;
            fval_q <= fval_nxt;
            lval_q <= lval_nxt;
            fpos_q <= fval_nxt & ~fval_q;
            lneg_q <= lval_q & ~lval_nxt;
            busy_q <= (state_nxt != ST_IDLE);
            pix_q  <= pix_nxt;
            line_q <= line_nxt;
        end
    end

`ifdef FRAME_TIMING_FRAME_COUNT_EN
    logic [CNT_W-1:0] frame_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_cnt_q <= '0;
        else if (fval_nxt & ~fval_q)
            frame_cnt_q <= frame_cnt_q + 1'b1;
    end

    assign bus.frame_count = frame_cnt_q;
`endif

    assign bus.fval         = fval_q;
    assign bus.lval         = lval_q;
    assign bus.dval         = lval_q;
    assign bus.fval_posedge = fpos_q;
    assign bus.lval_negedge = lneg_q;
    assign bus.busy         = busy_q;
    assign bus.pix_idx      = pix_q;
    assign bus.line_idx     = line_q;

endmodule

// File: tb/tb_frame_timing_gen.sv
// Scoreboard bench for frame_timing_gen: a per-frame position model predicts
// every output cycle; scenario tasks add aggregate and boundary checks.
module tb_frame_timing_gen;
    import frame_timing_pkg::*;

    localparam int DH = 8, RC = 4, HB = 2, VB = 3, FL = 1, LF = 1;
    localparam int SPAN      = RC*DH + (RC-1)*HB;
    localparam int FRAME_LEN = FL + SPAN + LF + VB;

    typedef struct packed {
        logic        fval, lval, dval, fpos, lneg, busy;
        logic [15:0] pix, line, fc;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    frame_timing_gen_if bus();

    frame_timing_gen #(
        .DVAL_HIGH(DH), .ROW_COUNT(RC), .H_BLANK(HB),
        .V_BLANK(VB), .FV_TO_LV(FL), .LV_TO_FV(LF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0, n_errors = 0;
    obs_t        exp_q[$];
    bit          m_in_frame = 1'b0;
    int          m_p = 0;
    logic [15:0] m_fc = '0;

    int          cyc = 0;
    int          n_fval, n_lval, n_fpos, n_lneg, max_pix, max_line;
    int          fpos_cyc[$];
    logic [15:0] fpos_fc[$];
    obs_t        last_o;

    // Expected outputs at position p of a frame, built from segment lengths.
    function automatic obs_t model_at(input bit inf, input int p, input logic [15:0] fc);
        obs_t e;
        int   q, l, r;
        e = '0;
`ifdef FRAME_TIMING_FRAME_COUNT_EN
        e.fc = fc;
`else
        e.fc = (fc == 16'hFFFF) ? 16'd0 : 16'd0;
`endif
        if (!inf) return e;
        e.busy = 1'b1;
        if (p < FL) begin
            e.fval = 1'b1;
            e.fpos = (p == 0);
        end else if (p < FL + SPAN) begin
            q = p - FL;
            l = q / (DH + HB);
            r = q % (DH + HB);
            e.fval = 1'b1;
            e.line = 16'(l);
            if (r < DH) begin
                e.lval = 1'b1;
                e.dval = 1'b1;
                e.pix  = 16'(r);
            end else begin
                e.lneg = (r == DH);
            end
        end else if (p < FL + SPAN + LF) begin
            e.fval = 1'b1;
            e.line = 16'(RC - 1);
            e.lneg = (p == FL + SPAN);
        end
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o      = '0;
        o.fval = bus.fval;
        o.lval = bus.lval;
        o.dval = bus.dval;
        o.fpos = bus.fval_posedge;
        o.lneg = bus.lval_negedge;
        o.busy = bus.busy;
        o.pix  = bus.pix_idx;
        o.line = bus.line_idx;
`ifdef FRAME_TIMING_FRAME_COUNT_EN
        o.fc   = bus.frame_count;
`endif
        return o;
    endfunction

    task automatic clear_obs();
        n_fval = 0; n_lval = 0; n_fpos = 0; n_lneg = 0; max_pix = 0; max_line = 0;
        fpos_cyc.delete();
        fpos_fc.delete();
    endtask

    // One clock: predict the cycle after the coming edge, drive en, compare.
    task automatic tick(input logic en_v);
        obs_t e, o;
        if (!m_in_frame) begin
            if (en_v) begin m_in_frame = 1'b1; m_p = 0; end
        end else if (m_p == FRAME_LEN - 1) begin
            if (en_v) m_p = 0;
            else      m_in_frame = 1'b0;
        end else begin
            m_p++;
        end
        if (m_in_frame && m_p == 0) m_fc++;
        exp_q.push_back(model_at(m_in_frame, m_p, m_fc));
        bus.en = en_v;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        o = sample();
        e = exp_q.pop_front();
        n_checks++;
        if (o !== e) begin
            n_errors++;
            $display("FAIL cycle_cmp cyc=%0d got=%h expected=%h", cyc, o, e);
        end
        last_o = o;
        if (o.fval) n_fval++;
        if (o.lval) n_lval++;
        if (o.lneg) n_lneg++;
        if (o.fpos) begin
            n_fpos++;
            fpos_cyc.push_back(cyc);
            fpos_fc.push_back(o.fc);
        end
        if (int'(o.pix)  > max_pix)  max_pix  = int'(o.pix);
        if (int'(o.line) > max_line) max_line = int'(o.line);
    endtask

    task automatic test_reset();
        obs_t o;
        bus.en = 1'b0;
        rst    = 1'b1;
        repeat (2) @(negedge clk);
        o = sample();
        n_checks++;
        if (o !== '0) begin n_errors++; $display("FAIL reset_outputs got=%h expected=0", o); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b expected=0", bus.busy); end
        rst = 1'b0;
        repeat (3) tick(1'b0);
    endtask

    task automatic test_continuous();
        clear_obs();
        repeat (3*FRAME_LEN) tick(1'b1);
        tick(1'b0);
        n_checks++;
        if (n_fval != 3*40) begin n_errors++; $display("FAIL cont_fval_cycles got=%0d expected=%0d", n_fval, 120); end
        n_checks++;
        if (3*FRAME_LEN + 1 - n_fval != 3*3 + 1) begin
            n_errors++; $display("FAIL cont_fval_low got=%0d expected=%0d", 3*FRAME_LEN + 1 - n_fval, 10);
        end
        n_checks++;
        if (n_fpos != 3) begin n_errors++; $display("FAIL cont_fpos_count got=%0d expected=3", n_fpos); end
        n_checks++;
        if (fpos_cyc.size() != 3 || fpos_cyc[1] - fpos_cyc[0] != 43 || fpos_cyc[2] - fpos_cyc[1] != 43) begin
            n_errors++; $display("FAIL cont_period got_pulses=%0d expected period=43", fpos_cyc.size());
        end
        n_checks++;
        if (n_lval != 3*32) begin n_errors++; $display("FAIL cont_lval_cycles got=%0d expected=96", n_lval); end
        n_checks++;
        if (n_lneg != 3*4) begin n_errors++; $display("FAIL cont_lneg_count got=%0d expected=12", n_lneg); end
        n_checks++;
        if (max_pix != 7 || max_line != 3) begin
            n_errors++; $display("FAIL cont_index_range got pix=%0d line=%0d expected pix=7 line=3", max_pix, max_line);
        end
`ifdef FRAME_TIMING_FRAME_COUNT_EN
        n_checks++;
        if (fpos_fc.size() != 3 || fpos_fc[0] !== 16'd1 || fpos_fc[1] !== 16'd2 || fpos_fc[2] !== 16'd3) begin
            n_errors++; $display("FAIL frame_count_seq got_n=%0d expected 1,2,3", fpos_fc.size());
        end
`endif
    endtask

    task automatic test_single_pulse();
        clear_obs();
        tick(1'b1);
        repeat (FRAME_LEN + 5) tick(1'b0);
        n_checks++;
        if (n_fpos != 1) begin n_errors++; $display("FAIL pulse_fpos got=%0d expected=1", n_fpos); end
        n_checks++;
        if (n_fval != 40) begin n_errors++; $display("FAIL pulse_fval_cycles got=%0d expected=40", n_fval); end
        n_checks++;
        if (last_o.busy !== 1'b0) begin n_errors++; $display("FAIL pulse_idle_busy got=%b expected=0", last_o.busy); end
    endtask

    task automatic test_en_drop();
        int i;
        clear_obs();
        repeat (FL + 2*(DH + HB) + 1) tick(1'b1);
        n_checks++;
        if (last_o.line !== 16'd2 || last_o.pix !== 16'd0) begin
            n_errors++; $display("FAIL drop_at_line2 got line=%0d pix=%0d expected line=2 pix=0", last_o.line, last_o.pix);
        end
        for (i = 0; i < 200 && (m_in_frame || last_o.busy); i++) tick(1'b0);
        repeat (4) tick(1'b0);
        n_checks++;
        if (last_o.busy !== 1'b0) begin n_errors++; $display("FAIL drop_drain got busy=%b expected=0", last_o.busy); end
        n_checks++;
        if (n_lneg != 4 || n_fpos != 1 || n_fval != 40) begin
            n_errors++; $display("FAIL drop_complete got lneg=%0d fpos=%0d fval=%0d expected 4 1 40", n_lneg, n_fpos, n_fval);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        clear_obs();
        repeat (FL + (DH + HB) + 6) tick(1'b1);
        n_checks++;
        if (last_o.pix !== 16'd5 || last_o.line !== 16'd1) begin
            n_errors++; $display("FAIL rmid_position got pix=%0d line=%0d expected pix=5 line=1", last_o.pix, last_o.line);
        end
        #2 rst = 1'b1;
        #1 o = sample();
        n_checks++;
        if (o !== '0) begin n_errors++; $display("FAIL rmid_async_zero got=%h expected=0", o); end
        @(posedge clk);
        #1 o = sample();
        n_checks++;
        if (o !== '0) begin n_errors++; $display("FAIL rmid_held_zero got=%h expected=0", o); end
        @(negedge clk);
        rst        = 1'b0;
        m_in_frame = 1'b0;
        m_p        = 0;
        m_fc       = '0;
        exp_q.delete();
        clear_obs();
        tick(1'b1);
        n_checks++;
        if (last_o.fpos !== 1'b1 || last_o.fval !== 1'b1 || last_o.line !== 16'd0) begin
            n_errors++; $display("FAIL rmid_restart got fpos=%b fval=%b line=%0d expected 1 1 0", last_o.fpos, last_o.fval, last_o.line);
        end
`ifdef FRAME_TIMING_FRAME_COUNT_EN
        n_checks++;
        if (last_o.fc !== 16'd1) begin n_errors++; $display("FAIL rmid_frame_count got=%0d expected=1", last_o.fc); end
`endif
        repeat (FRAME_LEN) tick(1'b0);
        n_checks++;
        if (n_fval != 40 || last_o.busy !== 1'b0) begin
            n_errors++; $display("FAIL rmid_frame got fval=%0d busy=%b expected 40 0", n_fval, last_o.busy);
        end
    endtask

    initial begin
        bus.en = 1'b0;
        test_reset();
        test_continuous();
        test_single_pulse();
        test_en_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
